// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared types and encodings for the pipeline hazard controller.
//   state_t         : hazard FSM state (RUN, MEM_WAIT, ERR)
//   FWD_*           : ALU operand forwarding select encodings
//   PCSRC_*         : PC source encodings held in ID/EX
//   reg_match()     : "this writer produces the register that source reads"
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  // Register $0 is hard-wired to zero, so a write to it never forwards.
  function automatic logic reg_match(input logic       we,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// pipe_fwd_unit
// Purely combinational EX-stage forwarding select.
// Ports:
//   EXRs, EXRt                       : source registers held in ID/EX
//   EXMEMRegWrite, EXMEMWriteReg     : EX/MEM writer
//   MEMWBRegWrite, MEMWBWriteReg     : MEM/WB writer
//   ForwardA, ForwardB               : operand selects (FWD_RF/FWD_MEMWB/FWD_EXMEM)
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] EXRs,
  input  logic [4:0] EXRt,
  input  logic       EXMEMRegWrite,
  input  logic [4:0] EXMEMWriteReg,
  input  logic       MEMWBRegWrite,
  input  logic [4:0] MEMWBWriteReg,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB
);

  logic [4:0] src_reg_sel [2];
  logic [1:0] fwd_sel     [2];

  assign src_reg_sel[0] = EXRs;
  assign src_reg_sel[1] = EXRt;

  // The EX/MEM result is younger than MEM/WB, so it takes precedence.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      always_comb begin
        fwd_sel[gi] = FWD_RF;
        if (reg_match(EXMEMRegWrite, EXMEMWriteReg, src_reg_sel[gi])) begin
          fwd_sel[gi] = FWD_EXMEM;
        end else if (reg_match(MEMWBRegWrite, MEMWBWriteReg, src_reg_sel[gi])) begin
          fwd_sel[gi] = FWD_MEMWB;
        end
      end
    end
  endgenerate

  assign ForwardA = fwd_sel[0];
  assign ForwardB = fwd_sel[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard controller for the 5-stage MIPS pipeline: drives the stage register
// enables/flushes for memory-wait freezes, branch/jump redirects and load-use
// stalls, supervises data-memory waits with a timeout, produces forwarding
// selects and keeps saturating stall/flush counters.
// Ports:
//   clk, rst (sync, active-low)
//   IDRs/IDRt/IDUsesRs/IDUsesRt      : ID-stage source operands
//   EXRs/EXRt/EXMemRead/EXPCSrc      : ID/EX contents
//   EXMEM*/MEMWB*                    : downstream register writers
//   MemReq, MemReady                 : data-memory handshake for EX/MEM
//   PCWrite..EXMEMWrite              : stage register enables
//   IFIDFlush/IDEXFlush/MEMWBFlush   : bubble insertion
//   ForwardA/ForwardB                : ALU operand selects
//   MemErr                           : sticky memory timeout flag
//   StallCount/FlushCount            : saturating performance counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IDRs,
  input  logic [4:0]       IDRt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic [4:0]       EXRs,
  input  logic [4:0]       EXRt,
  input  logic             EXMemRead,
  input  logic [1:0]       EXPCSrc,
  input  logic             EXMEMRegWrite,
  input  logic [4:0]       EXMEMWriteReg,
  input  logic             MEMWBRegWrite,
  input  logic [4:0]       MEMWBWriteReg,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MEMWBFlush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              mem_err_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  logic       mem_pending;
  logic       frozen;
  logic       redirect;
  logic       load_use;
  logic       pc_write_next;
  logic       ifid_write_next;
  logic       idex_write_next;
  logic       exmem_write_next;
  logic       ifid_flush_next;
  logic       idex_flush_next;
  logic       memwb_flush_next;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // ------------------------------------------------------------------
  // Hazard classification
  // ------------------------------------------------------------------
  assign mem_pending = MemReq && !MemReady;
  assign frozen      = (state_reg == ERR) || mem_pending;
  assign redirect    = !frozen && (EXPCSrc != PCSRC_SEQ);
  // A load into $0 never produces a value anyone waits for.
  assign load_use    = !frozen && !redirect && EXMemRead && (EXRt != 5'd0) &&
                       ((IDUsesRs && (EXRt == IDRs)) || (IDUsesRt && (EXRt == IDRt)));

  // ------------------------------------------------------------------
  // Stage control priority mux: reset > freeze > redirect > load-use
  // ------------------------------------------------------------------
  always_comb begin
    pc_write_next    = 1'b1;
    ifid_write_next  = 1'b1;
    idex_write_next  = 1'b1;
    exmem_write_next = 1'b1;
    ifid_flush_next  = 1'b0;
    idex_flush_next  = 1'b0;
    memwb_flush_next = 1'b0;
    if (!rst) begin
      pc_write_next    = 1'b0;
      ifid_write_next  = 1'b0;
      idex_write_next  = 1'b0;
      exmem_write_next = 1'b0;
      ifid_flush_next  = 1'b1;
      idex_flush_next  = 1'b1;
      memwb_flush_next = 1'b1;
    end else if (frozen) begin
      // Everything upstream of MEM/WB holds, so a pending redirect in ID/EX
      // survives and fires on the first unfrozen cycle.
      pc_write_next    = 1'b0;
      ifid_write_next  = 1'b0;
      idex_write_next  = 1'b0;
      exmem_write_next = 1'b0;
      memwb_flush_next = 1'b1;
    end else if (redirect) begin
      ifid_flush_next  = 1'b1;
      idex_flush_next  = 1'b1;
    end else if (load_use) begin
      pc_write_next    = 1'b0;
      ifid_write_next  = 1'b0;
      idex_flush_next  = 1'b1;
    end
  end

  assign PCWrite    = pc_write_next;
  assign IFIDWrite  = ifid_write_next;
  assign IDEXWrite  = idex_write_next;
  assign EXMEMWrite = exmem_write_next;
  assign IFIDFlush  = ifid_flush_next;
  assign IDEXFlush  = idex_flush_next;
  assign MEMWBFlush = memwb_flush_next;

  // ------------------------------------------------------------------
  // Forwarding
  // ------------------------------------------------------------------
  pipe_fwd_unit u_fwd (
    .EXRs          (EXRs),
    .EXRt          (EXRt),
    .EXMEMRegWrite (EXMEMRegWrite),
    .EXMEMWriteReg (EXMEMWriteReg),
    .MEMWBRegWrite (MEMWBRegWrite),
    .MEMWBWriteReg (MEMWBWriteReg),
    .ForwardA      (fwd_a_raw),
    .ForwardB      (fwd_b_raw)
  );

  assign ForwardA = rst ? fwd_a_raw : FWD_RF;
  assign ForwardB = rst ? fwd_b_raw : FWD_RF;

  // ------------------------------------------------------------------
  // Memory-wait FSM, timeout flag and performance counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          wait_cnt_reg <= '0;
          if (mem_pending) begin
            state_reg <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          if (MemReady) begin
            state_reg <= RUN;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg   <= ERR;
            mem_err_reg <= 1'b1;
          end
        end
        ERR: begin
          mem_err_reg <= 1'b1;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase

      if (!pc_write_next && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (redirect && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign MemErr     = mem_err_reg;
  assign StallCount = stall_cnt_reg;
  assign FlushCount = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed-vector bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are compared one
// further unit later, well away from the next edge.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBFlush}
  localparam logic [6:0] C_NORMAL  = 7'b1111_000;
  localparam logic [6:0] C_RESET   = 7'b0000_111;
  localparam logic [6:0] C_FREEZE  = 7'b0000_001;
  localparam logic [6:0] C_REDIR   = 7'b1111_110;
  localparam logic [6:0] C_LOADUSE = 7'b0011_010;

  logic             clk;
  logic             rst;
  logic [4:0]       IDRs, IDRt;
  logic             IDUsesRs, IDUsesRt;
  logic [4:0]       EXRs, EXRt;
  logic             EXMemRead;
  logic [1:0]       EXPCSrc;
  logic             EXMEMRegWrite;
  logic [4:0]       EXMEMWriteReg;
  logic             MEMWBRegWrite;
  logic [4:0]       MEMWBWriteReg;
  logic             MemReq, MemReady;
  logic             PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic             IFIDFlush, IDEXFlush, MEMWBFlush;
  logic [1:0]       ForwardA, ForwardB;
  logic             MemErr;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int n_checks = 0;
  int n_fails  = 0;

  logic [6:0] ctrl;
  assign ctrl = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBFlush};

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IDRs          (IDRs),
    .IDRt          (IDRt),
    .IDUsesRs      (IDUsesRs),
    .IDUsesRt      (IDUsesRt),
    .EXRs          (EXRs),
    .EXRt          (EXRt),
    .EXMemRead     (EXMemRead),
    .EXPCSrc       (EXPCSrc),
    .EXMEMRegWrite (EXMEMRegWrite),
    .EXMEMWriteReg (EXMEMWriteReg),
    .MEMWBRegWrite (MEMWBRegWrite),
    .MEMWBWriteReg (MEMWBWriteReg),
    .MemReq        (MemReq),
    .MemReady      (MemReady),
    .PCWrite       (PCWrite),
    .IFIDWrite     (IFIDWrite),
    .IDEXWrite     (IDEXWrite),
    .EXMEMWrite    (EXMEMWrite),
    .IFIDFlush     (IFIDFlush),
    .IDEXFlush     (IDEXFlush),
    .MEMWBFlush    (MEMWBFlush),
    .ForwardA      (ForwardA),
    .ForwardB      (ForwardB),
    .MemErr        (MemErr),
    .StallCount    (StallCount),
    .FlushCount    (FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %-16s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %-16s value=0x%0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    IDRs = 5'd0; IDRt = 5'd0; IDUsesRs = 1'b0; IDUsesRt = 1'b0;
    EXRs = 5'd0; EXRt = 5'd0; EXMemRead = 1'b0; EXPCSrc = PCSRC_SEQ;
    EXMEMRegWrite = 1'b0; EXMEMWriteReg = 5'd0;
    MEMWBRegWrite = 1'b0; MEMWBWriteReg = 5'd0;
    MemReq = 1'b0; MemReady = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic set_load_use();
    EXMemRead = 1'b1; EXRt = 5'd8; IDRs = 5'd8; IDUsesRs = 1'b1;
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    tick();
    tick();

    // ---------------- reset state ----------------
    check("rst_ctrl", 32'(ctrl), 32'(C_RESET));
    check("rst_stall", 32'(StallCount), 32'd0);
    check("rst_flush", 32'(FlushCount), 32'd0);
    check("rst_memerr", 32'(MemErr), 32'd0);
    EXMEMRegWrite = 1'b1; EXMEMWriteReg = 5'd5; EXRs = 5'd5;
    settle();
    check("rst_fwdA", 32'(ForwardA), 32'(FWD_RF));
    clear_in();
    rst = 1'b1;
    settle();
    check("idle_ctrl", 32'(ctrl), 32'(C_NORMAL));

    // ---------------- load-use ----------------
    set_load_use();
    settle();
    check("lu_ctrl", 32'(ctrl), 32'(C_LOADUSE));
    tick();
    EXMemRead = 1'b0;  // bubble now sits in ID/EX
    settle();
    check("lu_next_ctrl", 32'(ctrl), 32'(C_NORMAL));
    check("lu_stall", 32'(StallCount), 32'd1);
    // Source not actually read -> no stall
    EXMemRead = 1'b1; IDUsesRs = 1'b0;
    settle();
    check("lu_unused_src", 32'(ctrl), 32'(C_NORMAL));
    // Load into $0 never stalls
    EXRt = 5'd0; IDRs = 5'd0; IDUsesRs = 1'b1;
    settle();
    check("lu_reg0", 32'(ctrl), 32'(C_NORMAL));
    // Match on the Rt source
    EXRt = 5'd9; IDRt = 5'd9; IDUsesRt = 1'b1; IDRs = 5'd3;
    settle();
    check("lu_rt", 32'(ctrl), 32'(C_LOADUSE));
    tick();
    clear_in();
    settle();
    check("lu_rt_stall", 32'(StallCount), 32'd2);

    // ---------------- redirect over load-use ----------------
    set_load_use();
    EXPCSrc = PCSRC_BR;
    settle();
    check("redir_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick();
    clear_in();
    settle();
    check("redir_flush", 32'(FlushCount), 32'd1);
    check("redir_stall", 32'(StallCount), 32'd2);
    EXPCSrc = PCSRC_JR;
    settle();
    check("jr_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick();
    clear_in();
    settle();
    check("jr_flush", 32'(FlushCount), 32'd2);

    // ---------------- memory wait, redirect held under freeze ----------------
    do_reset();
    MemReq = 1'b1; MemReady = 1'b0; EXPCSrc = PCSRC_J;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mw_freeze%0d", i), 32'(ctrl), 32'(C_FREEZE));
      tick();
    end
    MemReady = 1'b1;
    settle();
    check("mw_ready_redir", 32'(ctrl), 32'(C_REDIR));
    tick();
    clear_in();
    settle();
    check("mw_stall", 32'(StallCount), 32'd3);
    check("mw_flush", 32'(FlushCount), 32'd1);
    // Back in RUN: a new miss must again take the full timeout budget
    // (checked below); an immediate hit never freezes.
    MemReq = 1'b1; MemReady = 1'b1;
    settle();
    check("mw_hit_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    clear_in();
    settle();
    check("mw_hit_stall", 32'(StallCount), 32'd3);

    // ---------------- timeout ----------------
    do_reset();
    MemReq = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("to_before_err", 32'(MemErr), 32'd0);
    check("to_freeze", 32'(ctrl), 32'(C_FREEZE));
    tick();
    settle();
    check("to_memerr", 32'(MemErr), 32'd1);
    MemReq = 1'b0; MemReady = 1'b1;
    settle();
    check("err_freeze", 32'(ctrl), 32'(C_FREEZE));
    tick();
    settle();
    check("err_sticky", 32'(MemErr), 32'd1);
    check("err_stall", 32'(StallCount), 32'd6);
    rst = 1'b0;
    settle();
    check("err_rst_ctrl", 32'(ctrl), 32'(C_RESET));
    tick();
    rst = 1'b1;
    clear_in();
    settle();
    check("err_rst_memerr", 32'(MemErr), 32'd0);
    check("err_rst_ctrl2", 32'(ctrl), 32'(C_NORMAL));
    check("err_rst_stall", 32'(StallCount), 32'd0);

    // ---------------- forwarding ----------------
    EXMEMRegWrite = 1'b1; EXMEMWriteReg = 5'd5;
    MEMWBRegWrite = 1'b1; MEMWBWriteReg = 5'd5;
    EXRs = 5'd5; EXRt = 5'd5;
    settle();
    check("fwdA_exmem", 32'(ForwardA), 32'(FWD_EXMEM));
    check("fwdB_exmem", 32'(ForwardB), 32'(FWD_EXMEM));
    EXMEMRegWrite = 1'b0;
    settle();
    check("fwdA_memwb", 32'(ForwardA), 32'(FWD_MEMWB));
    EXMEMRegWrite = 1'b1; EXMEMWriteReg = 5'd0; MEMWBWriteReg = 5'd0; EXRs = 5'd0;
    settle();
    check("fwdA_reg0", 32'(ForwardA), 32'(FWD_RF));
    EXMEMWriteReg = 5'd5; MEMWBWriteReg = 5'd6; EXRs = 5'd5; EXRt = 5'd6;
    settle();
    check("fwdA_split", 32'(ForwardA), 32'(FWD_EXMEM));
    check("fwdB_split", 32'(ForwardB), 32'(FWD_MEMWB));
    EXRs = 5'd7; EXRt = 5'd7;
    settle();
    check("fwd_nomatch", 32'({ForwardA, ForwardB}), 32'd0);

    // ---------------- stall counter saturation ----------------
    do_reset();
    set_load_use();
    for (int i = 0; i < 10; i++) tick();
    settle();
    check("sat_mid", 32'(StallCount), 32'd10);
    for (int i = 0; i < 10; i++) tick();
    settle();
    check("sat_stall", 32'(StallCount), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write-enable and flush controls. Resolves load-use stalls, branch/jump redirects and multi-cycle data-memory waits, with a timeout, and computes EX-stage forwarding selects. Keeps saturating stall and flush counters for performance debug.

## Interface
- MEM_TIMEOUT, 64: maximum wait cycles for one data-memory access before error (≥2)
- CNT_W, 16: width of performance counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- IDRs, IDRt  in  5 each  source registers of instruction in ID
- IDUsesRs, IDUsesRt  in  1 each  ID instruction actually reads that source
- EXRs, EXRt  in  5 each  source registers held in ID/EX
- EXMemRead  in  1  ID/EX holds a load
- EXPCSrc  in  2  ID/EX PC source: 00 PC+4, 01 branch taken, 10 jump, 11 jump-register
- EXMEMRegWrite  in  1  EX/MEM writes a register
- EXMEMWriteReg  in  5  EX/MEM destination
- MEMWBRegWrite  in  1  MEM/WB writes a register
- MEMWBWriteReg  in  5  MEM/WB destination
- MemReq  in  1  EX/MEM instruction accesses data memory (read or write)
- MemReady  in  1  data memory completes the access this cycle
- PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite  out  1 each  stage register enables
- IFIDFlush, IDEXFlush, MEMWBFlush  out  1 each  load zeros (bubble) into that register
- ForwardA, ForwardB  out  2 each  ALU operand select: 00 register file, 01 MEM/WB, 10 EX/MEM
- MemErr  out  1  sticky data-memory timeout flag
- StallCount, FlushCount  out  CNT_W each  saturating event counters

## Operation
- FSM states: RUN, MEM_WAIT, ERR.
- RUN→MEM_WAIT when MemReq && !MemReady. MEM_WAIT→RUN when MemReady. MEM_WAIT→ERR when WaitCnt == MEM_TIMEOUT-1 and !MemReady. ERR is left only by reset.
- Freeze (MemReq && !MemReady in RUN or MEM_WAIT, or state ERR): PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, MEMWBFlush=1, all other flushes 0.
- Redirect (not frozen, EXPCSrc != 00): IFIDFlush=1, IDEXFlush=1, all enables 1. Redirect wins over load-use.
- Load-use (not frozen, no redirect, EXMemRead && EXRt != 0 && ((IDUsesRs && EXRt == IDRs) || (IDUsesRt && EXRt == IDRt))): PCWrite=0, IFIDWrite=0, IDEXFlush=1, other enables 1.
- Otherwise all enables 1, all flushes 0.
- Priority: freeze > redirect > load-use. A redirect under freeze is not lost: ID/EX is held, so it takes effect in the first unfrozen cycle.
- Forwarding (independent of FSM): ForwardA=10 if EXMEMRegWrite && EXMEMWriteReg != 0 && EXMEMWriteReg == EXRs; else 01 if the same test holds on MEM/WB; else 00. ForwardB is identical using EXRt. The EX/MEM match wins over the MEM/WB match.
- WaitCnt: cleared in RUN, +1 per MEM_WAIT cycle. Width is clog2(MEM_TIMEOUT).
- StallCount: +1 per cycle with PCWrite=0. FlushCount: +1 per redirect cycle. Both saturate at all-ones and never wrap.

## Timing
- Stage controls and forward selects are combinational from the current state and inputs, so they act in the same cycle the hazard is visible.
- State, WaitCnt, MemErr and the counters are registered and update on the rising edge.
- Load-use costs exactly one bubble. Redirect costs two flushed slots.
- A memory access that completes on its first cycle (MemReady with MemReq) causes no freeze and no MEM_WAIT entry.
- MemErr rises the cycle after the timeout edge and stays 1 in ERR.
- While rst=0:
  - all enables 0; IFIDFlush, IDEXFlush and MEMWBFlush 1; Forward 00.
  - on the clock edge: state←RUN; WaitCnt, MemErr, StallCount and FlushCount←0.
- Reset asserted mid-wait or in ERR returns to RUN on that edge.

## Structure
- Shared package pipe_pkg holds:
  - state enum {RUN, MEM_WAIT, ERR};
  - forward encodings FWD_RF, FWD_MEMWB, FWD_EXMEM;
  - PCSrc encodings PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR.
- One natural sub-module: pipe_fwd_unit, purely combinational. It produces ForwardA/ForwardB and is instantiated once.
- FSM, priority mux and counters stay in the top module.

## Test plan
- Load-use: EXMemRead=1, EXRt=8, IDRs=8, IDUsesRs=1 → one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle all enables 1; StallCount=1.
- Redirect during a load-use condition: EXPCSrc=01 with the load-use inputs above → IFIDFlush=IDEXFlush=1, PCWrite=1; FlushCount=1, StallCount unchanged.
- Memory wait: MemReq=1, MemReady low for 3 cycles then high → freeze for 3 cycles; state returns to RUN on the ready edge; StallCount=3.
- Timeout, MEM_TIMEOUT=4: MemReady held low → ERR after the 4th wait cycle, MemErr=1, freeze held; rst=0 for one edge → RUN, MemErr=0.
- Forwarding: EXMEMWriteReg=MEMWBWriteReg=5, both RegWrite=1, EXRs=5 → ForwardA=10. With EXMEMRegWrite=0 → 01. With writes to register 0 → 00.
- Counter saturation, CNT_W=4: 20 load-use cycles → StallCount stays at 15.
